// File: rtl/input_debouncer.sv
// Debounces a raw level input: two-flop synchronizer, then a four-state
// qualification FSM that requires STABLE_CYCLES consecutive samples of a new
// level before the registered output Y follows. rise/fall are one-cycle
// registered pulses aligned with the Y transition.
module input_debouncer #(
  parameter int unsigned STABLE_CYCLES = 4,
  parameter int unsigned CNT_W         = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       I,
  output logic       Y,
  output logic       rise,
  output logic       fall,
  output logic [1:0] present_state
);

  typedef enum logic [1:0] {
    IDLE_LOW  = 2'b00,
    WAIT_HIGH = 2'b01,
    IDLE_HIGH = 2'b10,
    WAIT_LOW  = 2'b11
  } state_t;

  localparam logic [CNT_W-1:0] STABLE_N = CNT_W'(STABLE_CYCLES);
  localparam bit               SINGLE   = (STABLE_CYCLES == 1);

  logic             r_s1;
  logic             r_s2;
  state_t           r_state;
  state_t           w_next_state;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_next_cnt;
  logic [CNT_W-1:0] w_cnt_inc;
  logic             w_done;
  logic             r_y;
  logic             r_rise;
  logic             r_fall;
  logic             w_rise_next;
  logic             w_fall_next;

  // Next-state and counter logic; the FSM only ever looks at the synchronized r_s2.
  always_comb begin
    w_next_state = r_state;
    w_next_cnt   = '0;
    w_cnt_inc    = r_cnt + CNT_W'(1);
    w_done       = (w_cnt_inc == STABLE_N);
    case (r_state)
      IDLE_LOW: begin
        if (r_s2) begin
          if (SINGLE) begin
            w_next_state = IDLE_HIGH;
          end else begin
            w_next_state = WAIT_HIGH;
            w_next_cnt   = CNT_W'(1);
          end
        end
      end
      WAIT_HIGH: begin
        if (!r_s2) begin
          w_next_state = IDLE_LOW;
        end else if (w_done) begin
          w_next_state = IDLE_HIGH;
        end else begin
          w_next_cnt = w_cnt_inc;
        end
      end
      IDLE_HIGH: begin
        if (!r_s2) begin
          if (SINGLE) begin
            w_next_state = IDLE_LOW;
          end else begin
            w_next_state = WAIT_LOW;
            w_next_cnt   = CNT_W'(1);
          end
        end
      end
      WAIT_LOW: begin
        if (r_s2) begin
          w_next_state = IDLE_HIGH;
        end else if (w_done) begin
          w_next_state = IDLE_LOW;
        end else begin
          w_next_cnt = w_cnt_inc;
        end
      end
      default: begin
        w_next_state = IDLE_LOW;
      end
    endcase
  end

  // Edge pulses fire only when an IDLE state of the opposite level is actually entered.
  always_comb begin
    w_rise_next = 1'b0;
    w_fall_next = 1'b0;
    if ((w_next_state == IDLE_HIGH) &&
        ((r_state == IDLE_LOW) || (r_state == WAIT_HIGH))) begin
      w_rise_next = 1'b1;
    end
    if ((w_next_state == IDLE_LOW) &&
        ((r_state == IDLE_HIGH) || (r_state == WAIT_LOW))) begin
      w_fall_next = 1'b1;
    end
  end

  // Synchronizer, FSM state, counter and registered outputs; reset wins over everything.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_s1    <= 1'b0;
      r_s2    <= 1'b0;
      r_state <= IDLE_LOW;
      r_cnt   <= '0;
      r_y     <= 1'b0;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
    end else begin
      r_s1    <= I;
      r_s2    <= r_s1;
      r_state <= w_next_state;
      r_cnt   <= w_next_cnt;
      r_y     <= w_next_state[1];
      r_rise  <= w_rise_next;
      r_fall  <= w_fall_next;
    end
  end

  assign Y             = r_y;
  assign rise          = r_rise;
  assign fall          = r_fall;
  assign present_state = r_state;

endmodule

// File: tb/tb_input_debouncer.sv
// Directed bench for input_debouncer at default parameters, with a small
// downstream negedge detector modelled here to check the chained fall pulse.
module tb_input_debouncer;

  logic       clk;
  logic       reset;
  logic       I;
  logic       Y;
  logic       rise;
  logic       fall;
  logic [1:0] present_state;

  int checks   = 0;
  int failures = 0;

  logic nd_prev;
  logic nd_y;

  input_debouncer dut (
    .clk           (clk),
    .reset         (reset),
    .I             (I),
    .Y             (Y),
    .rise          (rise),
    .fall          (fall),
    .present_state (present_state)
  );

  // 10 ns clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Downstream negedge detector fed by the debounced Y
  always @(posedge clk) begin
    if (reset) begin
      nd_prev <= 1'b0;
      nd_y    <= 1'b0;
    end else begin
      nd_prev <= Y;
      nd_y    <= nd_prev & ~Y;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Compare {present_state, Y, rise, fall} against the hand-computed tuple
  task automatic exp5(input string tag, input logic [1:0] st, input logic ey,
                      input logic er, input logic ef);
    logic [4:0] obs;
    logic [4:0] expv;
    obs  = {present_state, Y, rise, fall};
    expv = {st, ey, er, ef};
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed={st,Y,rise,fall}=%b expected=%b", tag, obs, expv);
    end
  endtask

  task automatic exp1(input string tag, input logic obs, input logic expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, expv);
    end
  endtask

  initial begin
    reset = 1'b1;
    I     = 1'b0;

    // Reset state, then I=0 held for 20 cycles
    step();
    exp5("reset", 2'b00, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      exp5($sformatf("idle_low_%0d", i), 2'b00, 1'b0, 1'b0, 1'b0);
    end

    // Clean rise: I=1 before edge k, Y and rise at k+5
    I = 1'b1;
    step(); exp5("rise_k0", 2'b00, 1'b0, 1'b0, 1'b0);
    step(); exp5("rise_k1", 2'b00, 1'b0, 1'b0, 1'b0);
    step(); exp5("rise_k2", 2'b01, 1'b0, 1'b0, 1'b0);
    step(); exp5("rise_k3", 2'b01, 1'b0, 1'b0, 1'b0);
    step(); exp5("rise_k4", 2'b01, 1'b0, 1'b0, 1'b0);
    step(); exp5("rise_k5", 2'b10, 1'b1, 1'b1, 1'b0);
    step(); exp5("rise_k6", 2'b10, 1'b1, 1'b0, 1'b0);
    step(); exp5("rise_k7", 2'b10, 1'b1, 1'b0, 1'b0);

    // Two-cycle low glitch while Y=1 is rejected
    I = 1'b0;
    step(); exp5("glitch_k0", 2'b10, 1'b1, 1'b0, 1'b0);
    I = 1'b0;
    step(); exp5("glitch_k1", 2'b10, 1'b1, 1'b0, 1'b0);
    I = 1'b1;
    step(); exp5("glitch_k2", 2'b11, 1'b1, 1'b0, 1'b0);
    step(); exp5("glitch_k3", 2'b11, 1'b1, 1'b0, 1'b0);
    step(); exp5("glitch_k4", 2'b10, 1'b1, 1'b0, 1'b0);
    step(); exp5("glitch_k5", 2'b10, 1'b1, 1'b0, 1'b0);
    step(); exp5("glitch_k6", 2'b10, 1'b1, 1'b0, 1'b0);

    // Clean fall, chained into the negedge detector
    I = 1'b0;
    step(); exp5("fall_k0", 2'b10, 1'b1, 1'b0, 1'b0); exp1("nd_k0", nd_y, 1'b0);
    step(); exp5("fall_k1", 2'b10, 1'b1, 1'b0, 1'b0); exp1("nd_k1", nd_y, 1'b0);
    step(); exp5("fall_k2", 2'b11, 1'b1, 1'b0, 1'b0); exp1("nd_k2", nd_y, 1'b0);
    step(); exp5("fall_k3", 2'b11, 1'b1, 1'b0, 1'b0); exp1("nd_k3", nd_y, 1'b0);
    step(); exp5("fall_k4", 2'b11, 1'b1, 1'b0, 1'b0); exp1("nd_k4", nd_y, 1'b0);
    step(); exp5("fall_k5", 2'b00, 1'b0, 1'b0, 1'b1); exp1("nd_k5", nd_y, 1'b0);
    step(); exp5("fall_k6", 2'b00, 1'b0, 1'b0, 1'b0); exp1("nd_k6", nd_y, 1'b1);
    step(); exp5("fall_k7", 2'b00, 1'b0, 1'b0, 1'b0); exp1("nd_k7", nd_y, 1'b0);
    step(); exp5("fall_k8", 2'b00, 1'b0, 1'b0, 1'b0); exp1("nd_k8", nd_y, 1'b0);

    // Bounce 1,0,1,0 then held 1 from edge k+4: one rise at k+9
    I = 1'b1; step(); exp5("bounce_k0", 2'b00, 1'b0, 1'b0, 1'b0);
    I = 1'b0; step(); exp5("bounce_k1", 2'b00, 1'b0, 1'b0, 1'b0);
    I = 1'b1; step(); exp5("bounce_k2", 2'b01, 1'b0, 1'b0, 1'b0);
    I = 1'b0; step(); exp5("bounce_k3", 2'b00, 1'b0, 1'b0, 1'b0);
    I = 1'b1; step(); exp5("bounce_k4", 2'b01, 1'b0, 1'b0, 1'b0);
    step(); exp5("bounce_k5", 2'b00, 1'b0, 1'b0, 1'b0);
    step(); exp5("bounce_k6", 2'b01, 1'b0, 1'b0, 1'b0);
    step(); exp5("bounce_k7", 2'b01, 1'b0, 1'b0, 1'b0);
    step(); exp5("bounce_k8", 2'b01, 1'b0, 1'b0, 1'b0);
    step(); exp5("bounce_k9", 2'b10, 1'b1, 1'b1, 1'b0);
    step(); exp5("bounce_k10", 2'b10, 1'b1, 1'b0, 1'b0);
    step(); exp5("bounce_k11", 2'b10, 1'b1, 1'b0, 1'b0);

    // Reset asserted in WAIT_LOW while Y=1: no fall pulse
    I = 1'b0;
    step(); exp5("rstwait_k0", 2'b10, 1'b1, 1'b0, 1'b0);
    step(); exp5("rstwait_k1", 2'b10, 1'b1, 1'b0, 1'b0);
    step(); exp5("rstwait_k2", 2'b11, 1'b1, 1'b0, 1'b0);
    reset = 1'b1;
    step(); exp5("rstwait_k3", 2'b00, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      exp5($sformatf("rstwait_post_%0d", i), 2'b00, 1'b0, 1'b0, 1'b0);
    end

    // Reset with I=1 held: qualified afresh after release
    I     = 1'b1;
    reset = 1'b1;
    step(); exp5("rsthigh_r", 2'b00, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;
    step(); exp5("rsthigh_k0", 2'b00, 1'b0, 1'b0, 1'b0);
    step(); exp5("rsthigh_k1", 2'b00, 1'b0, 1'b0, 1'b0);
    step(); exp5("rsthigh_k2", 2'b01, 1'b0, 1'b0, 1'b0);
    step(); exp5("rsthigh_k3", 2'b01, 1'b0, 1'b0, 1'b0);
    step(); exp5("rsthigh_k4", 2'b01, 1'b0, 1'b0, 1'b0);
    step(); exp5("rsthigh_k5", 2'b10, 1'b1, 1'b1, 1'b0);
    step(); exp5("rsthigh_k6", 2'b10, 1'b1, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
